// File: rtl/test_harness_pkg.sv
// Shared types and arithmetic helpers for the test-sequencing controller.
package test_harness_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_HOLD = 2'd1,
        RUN      = 2'd2,
        FINISH   = 2'd3
    } state_t;

    localparam int MAX_CH = 16;

    // Clamps at max instead of wrapping; callers pass counters zero-extended to 32 bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, max})
            return max;
        return s[31:0];
    endfunction

    function automatic logic [4:0] popcount(input logic [MAX_CH-1:0] v, input int num_ch);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (i < num_ch && v[i])
                c = c + 5'd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/check_channel.sv
// Masked equality compare for one check channel; mask bit 0 marks a don't-care bit.
module check_channel #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] dut,
    input  logic [WIDTH-1:0] expd,
    input  logic [WIDTH-1:0] mask,
    output logic             fail
);

    assign fail = |((dut ^ expd) & mask);

endmodule

// File: rtl/test_harness_ctrl.sv
// Test-sequencing controller: DUT reset pulse, run-cycle counter, watchdog,
// multi-channel check scoring and first-failure capture.
module test_harness_ctrl
    import test_harness_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 32,
    parameter int RST_CYCLES = 3,
    parameter int TIMEOUT    = 10000,
    parameter int CYC_W      = 32,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     done,
    input  logic [NUM_CH-1:0]        chk_val,
    input  logic [NUM_CH*WIDTH-1:0]  chk_dut,
    input  logic [NUM_CH*WIDTH-1:0]  chk_ref,
    input  logic [NUM_CH*WIDTH-1:0]  chk_mask,
    output logic                     dut_rst,
    output logic [CYC_W-1:0]         cycles,
    output logic [1:0]               state,
    output logic                     timed_out,
    output logic [CNT_W-1:0]         n_checks,
    output logic [CNT_W-1:0]         n_fails,
    output logic                     pass,
    output logic                     fail_vld,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] fail_ch,
    output logic [CYC_W-1:0]         fail_cyc,
    output logic [WIDTH-1:0]         fail_dut,
    output logic [WIDTH-1:0]         fail_ref
);

    localparam int FCH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HC_W  = $clog2(RST_CYCLES + 1);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(RST_CYCLES - 1);
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(TIMEOUT - 1);
    localparam logic [31:0]      CNT_MAX   = 32'({CNT_W{1'b1}});

    state_t            st;
    logic [HC_W-1:0]   hold_cnt;
    logic [NUM_CH-1:0] ch_fail;
    logic [NUM_CH-1:0] acc_val;
    logic [NUM_CH-1:0] acc_fail;
    logic              accept;
    logic [4:0]        pop_chk;
    logic [4:0]        pop_fail;
    logic [FCH_W-1:0]  first_ch;
    logic [WIDTH-1:0]  first_dut;
    logic [WIDTH-1:0]  first_ref;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
        check_channel #(.WIDTH(WIDTH)) u_chk (
            .dut  (chk_dut[g*WIDTH +: WIDTH]),
            .expd (chk_ref[g*WIDTH +: WIDTH]),
            .mask (chk_mask[g*WIDTH +: WIDTH]),
            .fail (ch_fail[g])
        );
    end

    // Strobes count only in RUN, and not on the cycle that ends the run.
    assign accept   = (st == RUN) && !done;
    assign acc_val  = accept ? chk_val : '0;
    assign acc_fail = acc_val & ch_fail;
    assign pop_chk  = popcount(16'(acc_val), NUM_CH);
    assign pop_fail = popcount(16'(acc_fail), NUM_CH);

    always_comb begin
        first_ch  = '0;
        first_dut = '0;
        first_ref = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (acc_fail[i]) begin
                first_ch  = FCH_W'(i);
                first_dut = chk_dut[i*WIDTH +: WIDTH];
                first_ref = chk_ref[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= IDLE;
            dut_rst   <= 1'b1;
            hold_cnt  <= '0;
            cycles    <= '0;
            timed_out <= 1'b0;
            n_checks  <= '0;
            n_fails   <= '0;
            fail_vld  <= 1'b0;
            fail_ch   <= '0;
            fail_cyc  <= '0;
            fail_dut  <= '0;
            fail_ref  <= '0;
        end else begin
            case (st)
                IDLE, FINISH: begin
                    if (start) begin
                        st        <= RST_HOLD;
                        dut_rst   <= 1'b1;
                        hold_cnt  <= '0;
                        cycles    <= '0;
                        timed_out <= 1'b0;
                        n_checks  <= '0;
                        n_fails   <= '0;
                        fail_vld  <= 1'b0;
                        fail_ch   <= '0;
                        fail_cyc  <= '0;
                        fail_dut  <= '0;
                        fail_ref  <= '0;
                    end
                end
                RST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        st      <= RUN;
                        dut_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RUN: begin
                    cycles   <= cycles + 1'b1;
                    n_checks <= CNT_W'(sat_add(32'(n_checks), 32'(pop_chk), CNT_MAX));
                    n_fails  <= CNT_W'(sat_add(32'(n_fails), 32'(pop_fail), CNT_MAX));
                    if (|acc_fail && !fail_vld) begin
                        fail_vld <= 1'b1;
                        fail_ch  <= first_ch;
                        fail_cyc <= cycles;
                        fail_dut <= first_dut;
                        fail_ref <= first_ref;
                    end
                    // done takes priority over a watchdog expiry in the same cycle.
                    if (done) begin
                        st <= FINISH;
                    end else if (cycles == CYC_LAST) begin
                        st        <= FINISH;
                        timed_out <= 1'b1;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign state = st;
    assign pass  = (st == FINISH) && !timed_out && (n_fails == '0);

endmodule

// File: tb/tb_test_harness_ctrl.sv
// Scoreboard bench for test_harness_ctrl: a cycle model predicts every output,
// plus a second instance with narrow counters to exercise saturation.
module tb_test_harness_ctrl;

    localparam int NUM_CH     = 4;
    localparam int WIDTH      = 32;
    localparam int RST_CYCLES = 3;
    localparam int TIMEOUT    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic done = 1'b0;
    logic [NUM_CH-1:0]       chk_val = '0;
    logic [NUM_CH*WIDTH-1:0] chk_dut, chk_ref, chk_mask;
    logic [31:0] dv[NUM_CH];
    logic [31:0] rv[NUM_CH];
    logic [31:0] mv[NUM_CH];

    logic        a_dut_rst, a_timed_out, a_pass, a_fail_vld;
    logic [31:0] a_cycles, a_fail_cyc, a_fail_dut, a_fail_ref;
    logic [1:0]  a_state, a_fail_ch;
    logic [15:0] a_n_checks, a_n_fails;

    logic        b_dut_rst, b_timed_out, b_pass, b_fail_vld;
    logic [31:0] b_cycles, b_fail_cyc, b_fail_dut, b_fail_ref;
    logic [1:0]  b_state, b_fail_ch;
    logic [3:0]  b_n_checks, b_n_fails;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            chk_dut[i*WIDTH +: WIDTH]  = dv[i];
            chk_ref[i*WIDTH +: WIDTH]  = rv[i];
            chk_mask[i*WIDTH +: WIDTH] = mv[i];
        end
    end

    test_harness_ctrl #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .RST_CYCLES(RST_CYCLES),
                        .TIMEOUT(TIMEOUT), .CYC_W(32), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .done(done), .chk_val(chk_val),
        .chk_dut(chk_dut), .chk_ref(chk_ref), .chk_mask(chk_mask),
        .dut_rst(a_dut_rst), .cycles(a_cycles), .state(a_state), .timed_out(a_timed_out),
        .n_checks(a_n_checks), .n_fails(a_n_fails), .pass(a_pass), .fail_vld(a_fail_vld),
        .fail_ch(a_fail_ch), .fail_cyc(a_fail_cyc), .fail_dut(a_fail_dut), .fail_ref(a_fail_ref)
    );

    test_harness_ctrl #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .RST_CYCLES(RST_CYCLES),
                        .TIMEOUT(TIMEOUT), .CYC_W(32), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .done(done), .chk_val(chk_val),
        .chk_dut(chk_dut), .chk_ref(chk_ref), .chk_mask(chk_mask),
        .dut_rst(b_dut_rst), .cycles(b_cycles), .state(b_state), .timed_out(b_timed_out),
        .n_checks(b_n_checks), .n_fails(b_n_fails), .pass(b_pass), .fail_vld(b_fail_vld),
        .fail_ch(b_fail_ch), .fail_cyc(b_fail_cyc), .fail_dut(b_fail_dut), .fail_ref(b_fail_ref)
    );

    int n_asserts = 0;
    int n_errors  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h, required %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          m_st, m_hold;
    logic [31:0] m_cyc;
    logic        m_to, m_fvld;
    int          m_nchk, m_nfail, m_nchk_b, m_nfail_b;
    int          m_fch;
    logic [31:0] m_fcyc, m_fdut, m_fref;

    typedef struct {
        logic [31:0] st, drst, cyc, to, nchk, nfail, nchk_b, nfail_b, pass, fvld, fch, fcyc, fdut, fref;
    } exp_t;
    exp_t sb[$];

    task automatic model_clear();
        m_hold = 0; m_cyc = '0; m_to = 1'b0; m_fvld = 1'b0;
        m_nchk = 0; m_nfail = 0; m_nchk_b = 0; m_nfail_b = 0;
        m_fch = 0; m_fcyc = '0; m_fdut = '0; m_fref = '0;
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_step();
        int nc, nf, first;
        case (m_st)
            0, 3: if (start) begin model_clear(); m_st = 1; end
            1: begin
                if (m_hold == RST_CYCLES - 1) m_st = 2;
                else m_hold++;
            end
            default: begin
                if (!done) begin
                    nc = 0; nf = 0; first = -1;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (chk_val[i]) begin
                            nc++;
                            if (((dv[i] ^ rv[i]) & mv[i]) != 0) begin
                                nf++;
                                if (first < 0) first = i;
                            end
                        end
                    end
                    m_nchk = sat(m_nchk + nc, 65535);   m_nfail = sat(m_nfail + nf, 65535);
                    m_nchk_b = sat(m_nchk_b + nc, 15);  m_nfail_b = sat(m_nfail_b + nf, 15);
                    if (first >= 0 && !m_fvld) begin
                        m_fvld = 1'b1; m_fch = first; m_fcyc = m_cyc;
                        m_fdut = dv[first]; m_fref = rv[first];
                    end
                end
                if (done) m_st = 3;
                else if (m_cyc == 32'(TIMEOUT - 1)) begin m_st = 3; m_to = 1'b1; end
                m_cyc = m_cyc + 1;
            end
        endcase
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.st = 32'(m_st); e.drst = (m_st < 2) ? 1 : 0; e.cyc = m_cyc; e.to = 32'(m_to);
        e.nchk = 32'(m_nchk); e.nfail = 32'(m_nfail); e.nchk_b = 32'(m_nchk_b); e.nfail_b = 32'(m_nfail_b);
        e.pass = (m_st == 3 && !m_to && m_nfail == 0) ? 1 : 0;
        e.fvld = 32'(m_fvld); e.fch = 32'(m_fch); e.fcyc = m_fcyc; e.fdut = m_fdut; e.fref = m_fref;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        check("state", a_state, e.st);
        check("dut_rst", a_dut_rst, e.drst);
        check("cycles", a_cycles, e.cyc);
        check("timed_out", a_timed_out, e.to);
        check("n_checks", a_n_checks, e.nchk);
        check("n_fails", a_n_fails, e.nfail);
        check("pass", a_pass, e.pass);
        check("fail_vld", a_fail_vld, e.fvld);
        check("fail_ch", a_fail_ch, e.fch);
        check("fail_cyc", a_fail_cyc, e.fcyc);
        check("fail_dut", a_fail_dut, e.fdut);
        check("fail_ref", a_fail_ref, e.fref);
        check("b_n_checks", b_n_checks, e.nchk_b);
        check("b_n_fails", b_n_fails, e.nfail_b);
        check("b_state", b_state, e.st);
    endtask

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic step(input logic s, input logic d, input logic [NUM_CH-1:0] v);
        exp_t e;
        start = s; done = d; chk_val = v;
        model_step();
        sb.push_back(snapshot());
        @(posedge clk);
        #1;
        start = 1'b0; done = 1'b0; chk_val = '0;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            compare(e);
        end
    endtask

    task automatic begin_run();
        step(1'b1, 1'b0, '0);
        repeat (RST_CYCLES) step(1'b0, 1'b0, 4'hF);
    endtask

    task automatic restore_channels();
        for (int i = 0; i < NUM_CH; i++) begin
            dv[i] = 32'h1111_1111 * (i + 1);
            rv[i] = 32'h1111_1111 * (i + 1);
            mv[i] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, a_state, 0);
        check({tag, "_dut_rst"}, a_dut_rst, 1);
        check({tag, "_cycles"}, a_cycles, 0);
        check({tag, "_n_checks"}, a_n_checks, 0);
        check({tag, "_n_fails"}, a_n_fails, 0);
        check({tag, "_fail_vld"}, a_fail_vld, 0);
        check({tag, "_fail_cyc"}, a_fail_cyc, 0);
        check({tag, "_timed_out"}, a_timed_out, 0);
        check({tag, "_pass"}, a_pass, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual running, required finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        restore_channels();
        m_st = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;

        // Reset sequence and a clean 10-cycle run
        step(1'b0, 1'b0, 4'hF);
        begin_run();
        check("first_run_state", a_state, 2);
        check("first_run_cycles", a_cycles, 0);
        check("first_run_dut_rst", a_dut_rst, 0);
        repeat (10) step(1'b0, 1'b0, 4'hF);
        step(1'b0, 1'b1, 4'hF);
        check("clean_n_checks", a_n_checks, 40);
        check("clean_pass", a_pass, 1);

        // Two channels fail at cycles=5; lowest index is recorded
        begin_run();
        repeat (5) step(1'b0, 1'b0, 4'hF);
        dv[2] = 32'hDEAD_BEEF; rv[2] = 32'hDEAD_BEEE;
        dv[1] = 32'h0000_1234; rv[1] = 32'h0000_1235;
        step(1'b0, 1'b0, 4'hF);
        dv[1] = rv[1];
        step(1'b0, 1'b0, 4'hF);
        restore_channels();
        step(1'b0, 1'b1, 4'h0);
        check("rec_fail_ch", a_fail_ch, 1);
        check("rec_fail_cyc", a_fail_cyc, 5);
        check("rec_fail_dut", a_fail_dut, 32'h0000_1234);
        check("rec_n_fails", a_n_fails, 3);

        // Masked LSB and fully masked channel pass, then the watchdog fires
        begin_run();
        dv[2] = 32'hDEAD_BEEF; rv[2] = 32'hDEAD_BEEE; mv[2] = 32'hFFFF_FFFE;
        dv[3] = 32'hFFFF_FFFF; rv[3] = 32'h0; mv[3] = 32'h0;
        step(1'b0, 1'b0, 4'b0100);
        check("masked_n_checks", a_n_checks, 1);
        check("masked_fail_vld", a_fail_vld, 0);
        step(1'b0, 1'b0, 4'b1000);
        repeat (TIMEOUT - 2) step(1'b0, 1'b0, 4'hF);
        check("to_state", a_state, 3);
        check("to_flag", a_timed_out, 1);
        check("to_cycles", a_cycles, TIMEOUT);
        check("to_pass", a_pass, 0);
        check("sat_n_checks", b_n_checks, 15);
        repeat (2) step(1'b0, 1'b0, 4'hF);
        restore_channels();

        // done on the watchdog cycle wins
        begin_run();
        repeat (TIMEOUT - 1) step(1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        check("done_win_timed_out", a_timed_out, 0);
        check("done_win_pass", a_pass, 1);

        // Asynchronous abort mid-run
        begin_run();
        dv[0] = 32'h1; rv[0] = 32'h0;
        step(1'b0, 1'b0, 4'b0001);
        step(1'b0, 1'b0, 4'b0001);
        check("abort_pre_n_fails", a_n_fails, 2);
        #2 rst = 1'b1;
        #1;
        check_reset_values("abort");
        m_st = 0;
        model_clear();
        @(posedge clk);
        #1 rst = 1'b0;
        restore_channels();
        step(1'b0, 1'b0, 4'hF);
        begin_run();
        step(1'b0, 1'b0, 4'hF);
        step(1'b0, 1'b1, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_errors);
        $finish;
    end

endmodule
